pipeline_ctrl: RTL and testbench



---
 rtl/pipeline_ctrl_pkg.sv | 69 ++++++
 rtl/pipeline_ctrl_if.sv | 30 +++
 rtl/pipeline_ctrl_hazard_unit.sv | 34 +++
 rtl/pipeline_ctrl.sv | 138 +++++++++++++
 tb/tb_pipeline_ctrl.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the RV32I pipeline sequencer: instruction types,
// control-word field layout, the NOP word and branch fun3 codes.
package pipeline_ctrl_pkg;

    localparam int CW_W = 23;

    // Control-word field offsets
    localparam int TYPE_LSB = 0;
    localparam int FUN3_LSB = 4;
    localparam int FUN7_BIT = 7;
    localparam int RD_LSB   = 8;
    localparam int RS1_LSB  = 13;
    localparam int RS2_LSB  = 18;

    // instType encoding
    localparam logic [3:0] IT_LOAD   = 4'd0;
    localparam logic [3:0] IT_IMM    = 4'd1;
    localparam logic [3:0] IT_STORE  = 4'd2;
    localparam logic [3:0] IT_REG    = 4'd3;
    localparam logic [3:0] IT_LUI    = 4'd4;
    localparam logic [3:0] IT_AUIPC  = 4'd5;
    localparam logic [3:0] IT_BRANCH = 4'd6;
    localparam logic [3:0] IT_JALR   = 4'd7;
    localparam logic [3:0] IT_JAL    = 4'd8;

    // addi x0,x0,0
    localparam logic [CW_W-1:0] CWORD_NOP = 23'h000001;

    // Branch fun3 codes
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    function automatic logic [3:0] cw_type(input logic [CW_W-1:0] cw);
        return cw[TYPE_LSB +: 4];
    endfunction

    function automatic logic [2:0] cw_fun3(input logic [CW_W-1:0] cw);
        return cw[FUN3_LSB +: 3];
    endfunction

    function automatic logic [4:0] cw_rd(input logic [CW_W-1:0] cw);
        return cw[RD_LSB +: 5];
    endfunction

    function automatic logic [4:0] cw_rs1(input logic [CW_W-1:0] cw);
        return cw[RS1_LSB +: 5];
    endfunction

    function automatic logic [4:0] cw_rs2(input logic [CW_W-1:0] cw);
        return cw[RS2_LSB +: 5];
    endfunction

    // Instruction writes a non-zero destination register
    function automatic logic cw_is_writer(input logic [CW_W-1:0] cw);
        return (cw_type(cw) != IT_STORE) && (cw_type(cw) != IT_BRANCH) &&
               (cw_rd(cw) != 5'd0);
    endfunction

    // Instruction reads rs2
    function automatic logic cw_uses_rs2(input logic [CW_W-1:0] cw);
        return (cw_type(cw) == IT_STORE) || (cw_type(cw) == IT_REG) ||
               (cw_type(cw) == IT_BRANCH);
    endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Fetch and datapath bus between the pipeline sequencer (master) and the
// decoder / datapath (slave).
interface pipeline_ctrl_if;
    import pipeline_ctrl_pkg::*;

    logic [31:0]     fetch_pc;
    logic            if_valid;
    logic [CW_W-1:0] dec_cword;
    logic [31:0]     dec_imm;
    logic [CW_W-1:0] cwordID;
    logic [CW_W-1:0] cwordEX;
    logic [CW_W-1:0] cwordMEM;
    logic [CW_W-1:0] cwordWB;
    logic [31:0]     immEX;
    logic [31:0]     immMEM;
    logic [31:0]     pc;
    logic [3:0]      funit_ZCNVFlags;
    logic [31:0]     r_for_pc;

    modport master (
        output fetch_pc, cwordID, cwordEX, cwordMEM, cwordWB, immEX, immMEM, pc,
        input  if_valid, dec_cword, dec_imm, funit_ZCNVFlags, r_for_pc
    );

    modport slave (
        input  fetch_pc, cwordID, cwordEX, cwordMEM, cwordWB, immEX, immMEM, pc,
        output if_valid, dec_cword, dec_imm, funit_ZCNVFlags, r_for_pc
    );

endinterface

// File: rtl/pipeline_ctrl_hazard_unit.sv
// Combinational hazard detection: load-use between EX and ID, and jalr in ID
// waiting for any in-flight writer of its rs1 (r_for_pc is not forwarded).
module pipeline_ctrl_hazard_unit
    import pipeline_ctrl_pkg::*;
(
    input  logic [CW_W-1:0] cword_id,
    input  logic [CW_W-1:0] cword_ex,
    input  logic [CW_W-1:0] cword_mem,
    input  logic [CW_W-1:0] cword_wb,
    output logic            stall
);

    logic [4:0] rs1_id_s;
    logic [4:0] rs2_id_s;
    logic [4:0] rd_ex_s;
    logic       load_use_s;
    logic       jalr_haz_s;

    assign rs1_id_s = cw_rs1(cword_id);
    assign rs2_id_s = cw_rs2(cword_id);
    assign rd_ex_s  = cw_rd(cword_ex);

    assign load_use_s = (cw_type(cword_ex) == IT_LOAD) && (rd_ex_s != 5'd0) &&
                        ((rd_ex_s == rs1_id_s) ||
                         (cw_uses_rs2(cword_id) && (rd_ex_s == rs2_id_s)));

    assign jalr_haz_s = (cw_type(cword_id) == IT_JALR) &&
                        ((cw_is_writer(cword_ex)  && (cw_rd(cword_ex)  == rs1_id_s)) ||
                         (cw_is_writer(cword_mem) && (cw_rd(cword_mem) == rs1_id_s)) ||
                         (cw_is_writer(cword_wb)  && (cw_rd(cword_wb)  == rs1_id_s)));

    assign stall = load_use_s | jalr_haz_s;

endmodule

// File: rtl/pipeline_ctrl.sv
// Five-stage RV32I pipeline sequencer: owns the fetch PC and per-stage
// control words, inserts hazard bubbles and resolves control flow in EX.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    pipeline_ctrl_if.master   bus,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    logic [31:0]      fetch_pc_r;
    logic [CW_W-1:0]  cword_id_r;
    logic [31:0]      pc_id_r;
    logic [31:0]      imm_id_r;
    logic [CW_W-1:0]  cword_ex_r;
    logic [31:0]      pc_ex_r;
    logic [31:0]      imm_ex_r;
    logic [CW_W-1:0]  cword_mem_r;
    logic [31:0]      imm_mem_r;
    logic [CW_W-1:0]  cword_wb_r;
    logic [CNT_W-1:0] stall_cnt_r;
    logic [CNT_W-1:0] flush_cnt_r;

    logic             stall_s;
    logic             br_taken_s;
    logic             redirect_s;
    logic [31:0]      target_s;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    pipeline_ctrl_hazard_unit u_hazard (
        .cword_id  (cword_id_r),
        .cword_ex  (cword_ex_r),
        .cword_mem (cword_mem_r),
        .cword_wb  (cword_wb_r),
        .stall     (stall_s)
    );

    // Resolve branch / jal / jalr in EX; flags are Z,C,N,V on bits 3..0
    always_comb begin
        br_taken_s = 1'b0;
        redirect_s = 1'b0;
        target_s   = 32'h0000_0000;
        case (cw_fun3(cword_ex_r))
            F3_BEQ:  br_taken_s = bus.funit_ZCNVFlags[3];
            F3_BNE:  br_taken_s = ~bus.funit_ZCNVFlags[3];
            F3_BLT:  br_taken_s = bus.funit_ZCNVFlags[1] ^ bus.funit_ZCNVFlags[0];
            F3_BGE:  br_taken_s = ~(bus.funit_ZCNVFlags[1] ^ bus.funit_ZCNVFlags[0]);
            F3_BLTU: br_taken_s = ~bus.funit_ZCNVFlags[2];
            F3_BGEU: br_taken_s = bus.funit_ZCNVFlags[2];
            default: br_taken_s = 1'b0;
        endcase
        case (cw_type(cword_ex_r))
            IT_JAL: begin
                redirect_s = 1'b1;
                target_s   = pc_ex_r + imm_ex_r;
            end
            IT_JALR: begin
                redirect_s = 1'b1;
                target_s   = (bus.r_for_pc + imm_ex_r) & 32'hFFFF_FFFE;
            end
            IT_BRANCH: begin
                redirect_s = br_taken_s;
                target_s   = pc_ex_r + imm_ex_r;
            end
            default: begin
                redirect_s = 1'b0;
                target_s   = 32'h0000_0000;
            end
        endcase
    end

    // Pipeline advance: redirect beats stall beats fetch bubble beats normal
    always_ff @(posedge clk) begin
        if (!rst) begin
            fetch_pc_r  <= RESET_PC;
            cword_id_r  <= CWORD_NOP;
            pc_id_r     <= 32'h0000_0000;
            imm_id_r    <= 32'h0000_0000;
            cword_ex_r  <= CWORD_NOP;
            pc_ex_r     <= 32'h0000_0000;
            imm_ex_r    <= 32'h0000_0000;
            cword_mem_r <= CWORD_NOP;
            imm_mem_r   <= 32'h0000_0000;
            cword_wb_r  <= CWORD_NOP;
            stall_cnt_r <= {CNT_W{1'b0}};
            flush_cnt_r <= {CNT_W{1'b0}};
        end else begin
            cword_wb_r  <= cword_mem_r;
            cword_mem_r <= cword_ex_r;
            imm_mem_r   <= imm_ex_r;
            if (redirect_s) begin
                fetch_pc_r  <= target_s;
                cword_id_r  <= CWORD_NOP;
                imm_id_r    <= 32'h0000_0000;
                cword_ex_r  <= CWORD_NOP;
                imm_ex_r    <= 32'h0000_0000;
                flush_cnt_r <= sat_inc(flush_cnt_r);
            end else if (stall_s) begin
                cword_ex_r  <= CWORD_NOP;
                imm_ex_r    <= 32'h0000_0000;
                stall_cnt_r <= sat_inc(stall_cnt_r);
            end else begin
                cword_ex_r <= cword_id_r;
                pc_ex_r    <= pc_id_r;
                imm_ex_r   <= imm_id_r;
                if (bus.if_valid) begin
                    cword_id_r <= bus.dec_cword;
                    imm_id_r   <= bus.dec_imm;
                    pc_id_r    <= fetch_pc_r;
                    fetch_pc_r <= fetch_pc_r + 32'd4;
                end else begin
                    cword_id_r <= CWORD_NOP;
                    imm_id_r   <= 32'h0000_0000;
                end
            end
        end
    end

    assign bus.fetch_pc = fetch_pc_r;
    assign bus.cwordID  = cword_id_r;
    assign bus.cwordEX  = cword_ex_r;
    assign bus.cwordMEM = cword_mem_r;
    assign bus.cwordWB  = cword_wb_r;
    assign bus.pc       = pc_ex_r;
    assign bus.immEX    = imm_ex_r;
    assign bus.immMEM   = imm_mem_r;
    assign stall_cnt    = stall_cnt_r;
    assign flush_cnt    = flush_cnt_r;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: the driver pushes the hand-computed
// post-edge state for every cycle, the monitor pops and compares at negedge.
module tb_pipeline_ctrl;
    import pipeline_ctrl_pkg::*;

    localparam int CNT_W = 2;
    localparam logic [22:0] N = CWORD_NOP;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    pipeline_ctrl_if bus();

    pipeline_ctrl #(.RESET_PC(32'h0000_0000), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int               step;
        logic [9:0]       m;
        logic [31:0]      fpc, pc, imx, imm;
        logic [22:0]      cid, cex, cmem, cwb;
        logic [CNT_W-1:0] scnt, fcnt;
    } exp_t;

    exp_t q[$];
    exp_t e;
    exp_t mon_e;
    int   step_n = 0;
    int   n_chk  = 0;
    int   n_pass = 0;

    function automatic logic [22:0] mk(input logic [3:0] t, input logic [2:0] f3,
                                       input logic [4:0] rd, input logic [4:0] rs1,
                                       input logic [4:0] rs2);
        return {rs2, rs1, rd, 1'b0, f3, t};
    endfunction

    task automatic cmp(input string nm, input int st, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s step %0d: got %h expected %h", nm, st, act, exp);
    endtask

    // Monitor: compare the DUT state against the oldest expectation
    always @(negedge clk) begin
        if (q.size() != 0) begin
            mon_e = q.pop_front();
            if (mon_e.m[0]) cmp("fetch_pc", mon_e.step, bus.fetch_pc, mon_e.fpc);
            if (mon_e.m[1]) cmp("cwordID",  mon_e.step, {9'd0, bus.cwordID},  {9'd0, mon_e.cid});
            if (mon_e.m[2]) cmp("cwordEX",  mon_e.step, {9'd0, bus.cwordEX},  {9'd0, mon_e.cex});
            if (mon_e.m[3]) cmp("cwordMEM", mon_e.step, {9'd0, bus.cwordMEM}, {9'd0, mon_e.cmem});
            if (mon_e.m[4]) cmp("cwordWB",  mon_e.step, {9'd0, bus.cwordWB},  {9'd0, mon_e.cwb});
            if (mon_e.m[5]) cmp("pc",       mon_e.step, bus.pc, mon_e.pc);
            if (mon_e.m[6]) cmp("immEX",    mon_e.step, bus.immEX, mon_e.imx);
            if (mon_e.m[7]) cmp("immMEM",   mon_e.step, bus.immMEM, mon_e.imm);
            if (mon_e.m[8]) cmp("stall_cnt", mon_e.step, 32'(stall_cnt), 32'(mon_e.scnt));
            if (mon_e.m[9]) cmp("flush_cnt", mon_e.step, 32'(flush_cnt), 32'(mon_e.fcnt));
        end
    end

    task automatic x_fpc(input logic [31:0] v);
        e.m[0] = 1'b1; e.fpc = v;
    endtask
    task automatic x_cw(input logic [22:0] id, input logic [22:0] ex,
                        input logic [22:0] mem, input logic [22:0] wb);
        e.m[4:1] = 4'hF; e.cid = id; e.cex = ex; e.cmem = mem; e.cwb = wb;
    endtask
    task automatic x_ex(input logic [31:0] p, input logic [31:0] i);
        e.m[6:5] = 2'b11; e.pc = p; e.imx = i;
    endtask
    task automatic x_imm(input logic [31:0] v);
        e.m[7] = 1'b1; e.imm = v;
    endtask
    task automatic x_cnt(input logic [CNT_W-1:0] s, input logic [CNT_W-1:0] f);
        e.m[9:8] = 2'b11; e.scnt = s; e.fcnt = f;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        e.step = step_n;
        step_n++;
        q.push_back(e);
        e.m = '0;
    endtask

    task automatic drv(input logic v, input logic [22:0] cw, input logic [31:0] imm);
        bus.if_valid  = v;
        bus.dec_cword = cw;
        bus.dec_imm   = imm;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        x_fpc(32'h0); x_cw(N, N, N, N); x_ex(32'h0, 32'h0); x_imm(32'h0); x_cnt('0, '0);
        tick();
        rst = 1'b1;
    endtask

    // Branch at pc 0x20 with immEX 0x40 evaluated on the given flags
    task automatic run_branch(input logic [2:0] f3, input logic [3:0] flags, input logic taken);
        logic [22:0] br, b1, b2;
        br = mk(IT_BRANCH, f3, 5'd0, 5'd1, 5'd2);
        b1 = mk(IT_IMM, 3'd0, 5'd7, 5'd0, 5'd0);
        b2 = mk(IT_IMM, 3'd0, 5'd8, 5'd0, 5'd0);
        do_reset();
        bus.funit_ZCNVFlags = 4'h0;
        for (int i = 0; i < 8; i++) begin
            drv(1'b1, N, 32'h0); x_fpc(32'(4 * (i + 1))); tick();
        end
        drv(1'b1, br, 32'h40); x_fpc(32'h24); x_cw(br, N, N, N); tick();
        drv(1'b1, b1, 32'h0);  x_fpc(32'h28); x_cw(b1, br, N, N); x_ex(32'h20, 32'h40); tick();
        bus.funit_ZCNVFlags = flags;
        drv(1'b1, b2, 32'h0);
        if (taken) begin
            x_fpc(32'h60); x_cw(N, N, br, N); x_cnt(2'd0, 2'd1);
        end else begin
            x_fpc(32'h2C); x_cw(b2, b1, br, N); x_cnt(2'd0, 2'd0);
        end
        tick();
        bus.funit_ZCNVFlags = 4'h0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [22:0] a1, a2, a3, a4, ld, ad, bb, jr, jl;
        a1 = mk(IT_IMM, 3'd0, 5'd1, 5'd0, 5'd0);
        a2 = mk(IT_IMM, 3'd0, 5'd2, 5'd0, 5'd0);
        a3 = mk(IT_IMM, 3'd0, 5'd3, 5'd0, 5'd0);
        a4 = mk(IT_IMM, 3'd0, 5'd4, 5'd0, 5'd0);
        ld = mk(IT_LOAD, 3'd2, 5'd5, 5'd0, 5'd0);
        ad = mk(IT_REG, 3'd0, 5'd6, 5'd5, 5'd1);
        bb = mk(IT_IMM, 3'd0, 5'd7, 5'd0, 5'd0);
        jr = mk(IT_JALR, 3'd0, 5'd0, 5'd1, 5'd0);
        jl = mk(IT_JAL, 3'd0, 5'd1, 5'd0, 5'd0);
        e.m = '0;
        bus.funit_ZCNVFlags = 4'h0;
        bus.r_for_pc = 32'h0;
        drv(1'b0, N, 32'h0);

        // Straight-line addi stream
        do_reset();
        drv(1'b1, a1, 32'h11); x_fpc(32'd4);  x_cw(a1, N, N, N); x_cnt(2'd0, 2'd0); tick();
        drv(1'b1, a2, 32'h12); x_fpc(32'd8);  x_cw(a2, a1, N, N); x_ex(32'h0, 32'h11); tick();
        drv(1'b1, a3, 32'h13); x_fpc(32'd12); x_cw(a3, a2, a1, N); x_ex(32'h4, 32'h12); x_imm(32'h11); tick();
        drv(1'b1, a4, 32'h14); x_fpc(32'd16); x_cw(a4, a3, a2, a1); x_imm(32'h12); x_cnt(2'd0, 2'd0); tick();

        // Load-use: lw x5; add x6,x5,x1
        do_reset();
        drv(1'b1, ld, 32'h0); x_fpc(32'd4); x_cw(ld, N, N, N); tick();
        drv(1'b1, ad, 32'h0); x_fpc(32'd8); x_cw(ad, ld, N, N); tick();
        drv(1'b1, bb, 32'h0); x_fpc(32'd8); x_cw(ad, N, ld, N); x_cnt(2'd1, 2'd0); tick();
        drv(1'b1, bb, 32'h0); x_fpc(32'd12); x_cw(bb, ad, N, ld); x_ex(32'h4, 32'h0); x_cnt(2'd1, 2'd0); tick();

        // Branch condition table (flags Z,C,N,V)
        run_branch(F3_BEQ,  4'b1000, 1'b1);
        run_branch(F3_BEQ,  4'b0000, 1'b0);
        run_branch(F3_BNE,  4'b0000, 1'b1);
        run_branch(F3_BNE,  4'b1000, 1'b0);
        run_branch(F3_BLT,  4'b0010, 1'b1);
        run_branch(F3_BLT,  4'b0011, 1'b0);
        run_branch(F3_BGE,  4'b0011, 1'b1);
        run_branch(F3_BGE,  4'b0001, 1'b0);
        run_branch(F3_BLTU, 4'b0100, 1'b0);
        run_branch(F3_BLTU, 4'b0000, 1'b1);
        run_branch(F3_BGEU, 4'b0100, 1'b1);
        run_branch(F3_BGEU, 4'b0000, 1'b0);
        run_branch(3'b010,  4'b1111, 1'b0);

        // jalr at 0x10 waiting on addi x1, then a saturating load-use stall
        do_reset();
        drv(1'b1, N, 32'h0);  x_fpc(32'h04); x_cw(N, N, N, N); tick();
        drv(1'b1, N, 32'h0);  x_fpc(32'h08); tick();
        drv(1'b1, N, 32'h0);  x_fpc(32'h0C); tick();
        drv(1'b1, a1, 32'h0); x_fpc(32'h10); x_cw(a1, N, N, N); tick();
        drv(1'b1, jr, 32'h4); x_fpc(32'h14); x_cw(jr, a1, N, N); tick();
        drv(1'b1, bb, 32'h0); x_fpc(32'h14); x_cw(jr, N, a1, N); x_cnt(2'd1, 2'd0); tick();
        x_fpc(32'h14); x_cw(jr, N, N, a1); x_cnt(2'd2, 2'd0); tick();
        x_fpc(32'h14); x_cw(jr, N, N, N);  x_cnt(2'd3, 2'd0); tick();
        x_fpc(32'h18); x_cw(bb, jr, N, N); x_ex(32'h10, 32'h4); x_cnt(2'd3, 2'd0); tick();
        bus.r_for_pc = 32'h101;
        x_fpc(32'h104); x_cw(N, N, jr, N); x_cnt(2'd3, 2'd1); tick();
        bus.r_for_pc = 32'h0;
        drv(1'b1, ld, 32'h0); x_fpc(32'h108); x_cw(ld, N, N, jr); tick();
        drv(1'b1, ad, 32'h0); x_fpc(32'h10C); x_cw(ad, ld, N, N); tick();
        drv(1'b1, bb, 32'h0); x_fpc(32'h10C); x_cw(ad, N, ld, N); x_cnt(2'd3, 2'd1); tick();

        // jal redirect in EX together with a jalr hazard in ID
        do_reset();
        drv(1'b1, jl, 32'h100); x_fpc(32'h4); x_cw(jl, N, N, N); tick();
        drv(1'b1, jr, 32'h0);   x_fpc(32'h8); x_cw(jr, jl, N, N); x_ex(32'h0, 32'h100); tick();
        drv(1'b1, bb, 32'h0);   x_fpc(32'h100); x_cw(N, N, jl, N); x_cnt(2'd0, 2'd1); tick();

        // Fetch bubbles, then reset mid-stream
        do_reset();
        drv(1'b1, a1, 32'h11); x_fpc(32'h4); x_cw(a1, N, N, N); tick();
        drv(1'b0, a2, 32'h22); x_fpc(32'h4); x_cw(N, a1, N, N); x_ex(32'h0, 32'h11); tick();
        drv(1'b0, a2, 32'h22); x_fpc(32'h4); x_cw(N, N, a1, N); tick();
        drv(1'b1, a2, 32'h12); x_fpc(32'h8); x_cw(a2, N, N, a1); tick();
        drv(1'b1, a3, 32'h13);
        do_reset();

        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        cmp("drain", step_n, 32'(q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
